// File: rtl/dom_rnd_source_pkg.sv
// Shared constants, width helpers and state encoding for the DOM randomness source.
package dom_rnd_pkg;

  localparam int LFSR_W = 31;
  localparam int TAP_A  = 0;
  localparam int TAP_B  = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEED = 2'd1,
    ST_WARM = 2'd2,
    ST_RUN  = 2'd3
  } state_e;

  // The first-order two-share multiplier shares a single blinding nibble.
  function automatic int blind_nrnd(input int shares, input int foo);
    return (foo == 1 && shares == 2) ? 1 : shares;
  endfunction

  function automatic int zw_width(input int shares);
    return 2 * shares * (shares - 1);
  endfunction

  function automatic int rnd_width(input int shares, input int foo);
    return 2 * zw_width(shares) + 4 * blind_nrnd(shares, foo);
  endfunction

endpackage

// File: rtl/dom_rnd_source_if.sv
// Seed-load and randomness-delivery signals of the DOM randomness source.
interface dom_rnd_source_if
  import dom_rnd_pkg::*;
#(
  parameter int SHARES                   = 2,
  parameter int FIRST_ORDER_OPTIMIZATION = 1
);

  localparam int ZW = zw_width(SHARES);
  localparam int BW = 4 * blind_nrnd(SHARES, FIRST_ORDER_OPTIMIZATION);

  logic [31:0]   SeedxDI;
  logic          SeedValidxSI;
  logic          SeedReadyxSO;
  logic          ReseedxSI;
  logic          RndReadyxSI;
  logic          RndValidxSO;
  logic [ZW-1:0] Z1xDO;
  logic [ZW-1:0] Z2xDO;
  logic [BW-1:0] BxDO;
  logic          NeedSeedxSO;

  modport master (
    input  SeedxDI, SeedValidxSI, ReseedxSI, RndReadyxSI,
    output SeedReadyxSO, RndValidxSO, Z1xDO, Z2xDO, BxDO, NeedSeedxSO
  );

  modport slave (
    output SeedxDI, SeedValidxSI, ReseedxSI, RndReadyxSI,
    input  SeedReadyxSO, RndValidxSO, Z1xDO, Z2xDO, BxDO, NeedSeedxSO
  );

endinterface

// File: rtl/dom_rnd_source_lfsr31_step.sv
// Next state and output bit of one x^31+x^28+1 Fibonacci LFSR shifting right.
module lfsr31_step
  import dom_rnd_pkg::*;
(
  input  logic [LFSR_W-1:0] state_i,
  output logic [LFSR_W-1:0] next_o,
  output logic              bit_o
);

  assign next_o = {state_i[TAP_A] ^ state_i[TAP_B], state_i[LFSR_W-1:1]};
  assign bit_o  = state_i[0];

endmodule

// File: rtl/dom_rnd_source.sv
// Fresh-randomness producer for paired DOM GF(4) multipliers: seeded LFSR bank
// with serial seed load, warm-up, and a valid/ready word stream.
module dom_rnd_source
  import dom_rnd_pkg::*;
#(
  parameter int SHARES                   = 2,
  parameter int FIRST_ORDER_OPTIMIZATION = 1,
  parameter int WARMUP_CYCLES            = 64
) (
  input logic              ClkxCI,
  input logic              RstxRI,
  dom_rnd_source_if.master rnd_if
);

  localparam int RND_W  = rnd_width(SHARES, FIRST_ORDER_OPTIMIZATION);
  localparam int CNT_W  = (RND_W > 1) ? $clog2(RND_W) : 1;
  localparam int WCNT_W = (WARMUP_CYCLES > 0) ? $clog2(WARMUP_CYCLES + 1) : 1;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   seedCnt_q, seedCnt_d;
  logic [WCNT_W-1:0]  warmCnt_q, warmCnt_d;
  logic               seedReady_q, seedReady_d;
  logic [LFSR_W-1:0]  lfsr_q [RND_W];
  logic [LFSR_W-1:0]  lfsrNext [RND_W];
  logic [RND_W-1:0]   rndBits;
  logic               stepAll;
  logic               seedWr;
  logic               seedAccept;
  logic [LFSR_W-1:0]  seedVal;
  logic               unusedSeedMsb;

  assign seedAccept    = rnd_if.SeedValidxSI & seedReady_q;
  assign unusedSeedMsb = rnd_if.SeedxDI[31];
  // An all-zero seed would lock the LFSR up, so it is promoted to 1.
  assign seedVal = (rnd_if.SeedxDI[LFSR_W-1:0] == '0) ? LFSR_W'(1) : rnd_if.SeedxDI[LFSR_W-1:0];

  for (genvar k = 0; k < RND_W; k++) begin : g_lfsr
    lfsr31_step u_step (
      .state_i(lfsr_q[k]),
      .next_o (lfsrNext[k]),
      .bit_o  (rndBits[k])
    );
  end

  always_comb begin
    state_d   = state_q;
    seedCnt_d = seedCnt_q;
    warmCnt_d = warmCnt_q;
    stepAll   = 1'b0;
    seedWr    = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_SEED: begin
        if (seedAccept) begin
          seedWr = 1'b1;
          if (seedCnt_q == CNT_W'(RND_W - 1)) begin
            state_d   = ST_WARM;
            seedCnt_d = '0;
            warmCnt_d = '0;
          end else begin
            state_d   = ST_SEED;
            seedCnt_d = seedCnt_q + CNT_W'(1);
          end
        end
      end
      ST_WARM: begin
        // The final WARM cycle never steps, which also covers a zero-length warm-up.
        if (warmCnt_q == WCNT_W'(WARMUP_CYCLES)) begin
          state_d = ST_RUN;
        end else begin
          stepAll   = 1'b1;
          warmCnt_d = warmCnt_q + WCNT_W'(1);
        end
      end
      ST_RUN: begin
        stepAll = rnd_if.RndReadyxSI;
        if (rnd_if.ReseedxSI) begin
          state_d   = ST_SEED;
          seedCnt_d = '0;
        end
      end
    endcase
    seedReady_d = (state_d == ST_IDLE) || (state_d == ST_SEED);
  end

  always_ff @(posedge ClkxCI) begin
    if (RstxRI) begin
      state_q     <= ST_IDLE;
      seedCnt_q   <= '0;
      warmCnt_q   <= '0;
      seedReady_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      seedCnt_q   <= seedCnt_d;
      warmCnt_q   <= warmCnt_d;
      seedReady_q <= seedReady_d;
    end
  end

  always_ff @(posedge ClkxCI) begin
    for (int k = 0; k < RND_W; k++) begin
      if (RstxRI) begin
        lfsr_q[k] <= '0;
      end else if (seedWr && (seedCnt_q == CNT_W'(k))) begin
        lfsr_q[k] <= seedVal;
      end else if (stepAll) begin
        lfsr_q[k] <= lfsrNext[k];
      end
    end
  end

  assign rnd_if.RndValidxSO  = (state_q == ST_RUN);
  assign rnd_if.SeedReadyxSO = seedReady_q;
  assign rnd_if.NeedSeedxSO  = (state_q == ST_IDLE) || (state_q == ST_SEED);
  assign {rnd_if.BxDO, rnd_if.Z2xDO, rnd_if.Z1xDO} = (state_q == ST_RUN) ? rndBits : '0;

endmodule

// File: tb/tb_dom_rnd_source.sv
// Scoreboard bench for dom_rnd_source: one instance without warm-up, one with 64 warm-up steps.
module tb_dom_rnd_source;

  localparam int RND_W = 12;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic [31:0] seedData = '0;
  logic seedValid = 1'b0;
  logic reseedA = 1'b0;
  logic readyA = 1'b0;

  int errors = 0;
  int checks = 0;

  logic [31:0] seedVals [RND_W];
  logic [30:0] mdl [RND_W];
  logic [11:0] expQ [$];

  always #5 clock = ~clock;

  dom_rnd_source_if ifA ();
  dom_rnd_source_if ifB ();

  assign ifA.SeedxDI      = seedData;
  assign ifA.SeedValidxSI = seedValid;
  assign ifA.ReseedxSI    = reseedA;
  assign ifA.RndReadyxSI  = readyA;
  assign ifB.SeedxDI      = seedData;
  assign ifB.SeedValidxSI = seedValid;
  assign ifB.ReseedxSI    = 1'b0;
  assign ifB.RndReadyxSI  = 1'b0;

  dom_rnd_source #(.WARMUP_CYCLES(0)) dutA (
    .ClkxCI(clock),
    .RstxRI(reset),
    .rnd_if(ifA)
  );

  dom_rnd_source #(.WARMUP_CYCLES(64)) dutB (
    .ClkxCI(clock),
    .RstxRI(reset),
    .rnd_if(ifB)
  );

  wire [11:0] wordA = {ifA.BxDO, ifA.Z2xDO, ifA.Z1xDO};
  wire [11:0] wordB = {ifB.BxDO, ifB.Z2xDO, ifB.Z1xDO};

  // Reference LFSR bank: x^31+x^28+1, output bit is the current LSB.
  function automatic logic [11:0] mdl_word();
    logic [11:0] w;
    for (int k = 0; k < RND_W; k++) w[k] = mdl[k][0];
    return w;
  endfunction

  task automatic mdl_step();
    for (int k = 0; k < RND_W; k++) mdl[k] = {mdl[k][0] ^ mdl[k][3], mdl[k][30:1]};
  endtask

  task automatic load_model();
    for (int k = 0; k < RND_W; k++)
      mdl[k] = (seedVals[k][30:0] == 31'd0) ? 31'd1 : seedVals[k][30:0];
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Every transfer on instance A pops the next expected word.
  always @(negedge clock) begin
    if (ifA.RndValidxSO === 1'b1 && readyA === 1'b1) begin
      checks++;
      if (expQ.size() == 0) begin
        errors++;
        $display("[TB] FAIL scoreboard_underflow: got word %h with no expected entry", wordA);
      end else begin
        logic [11:0] exp;
        exp = expQ.pop_front();
        if (wordA !== exp) begin
          errors++;
          $display("[TB] FAIL scoreboard_word: got %h expected %h", wordA, exp);
        end
      end
    end
    if (ifA.RndValidxSO === 1'b0) begin
      checks++;
      if (wordA !== 12'h000) begin
        errors++;
        $display("[TB] FAIL gating: got %h expected 000 while invalid", wordA);
      end
    end
  end

  task automatic seed_beats(input int first, input int n);
    int waitCnt;
    for (int i = first; i < first + n; i++) begin
      seedData  = seedVals[i];
      seedValid = 1'b1;
      waitCnt   = 0;
      while (ifA.SeedReadyxSO !== 1'b1 && waitCnt < 50) begin
        tick();
        waitCnt++;
      end
      if (waitCnt >= 50) begin
        checks++;
        errors++;
        $display("[TB] FAIL seed_ready_timeout: beat %0d never accepted", i);
      end
      tick();
    end
    seedValid = 1'b0;
  endtask

  task automatic run_xfers(input int n);
    for (int i = 0; i < n; i++) begin
      readyA = 1'b1;
      if (ifA.RndValidxSO === 1'b1) begin
        expQ.push_back(mdl_word());
        mdl_step();
      end
      tick();
    end
    readyA = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    checks++;
    if (ifA.RndValidxSO !== 1'b0 || ifA.SeedReadyxSO !== 1'b0 || ifA.NeedSeedxSO !== 1'b1 || wordA !== 12'h000) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got valid=%b ready=%b need=%b word=%h expected 0 0 1 000",
               ifA.RndValidxSO, ifA.SeedReadyxSO, ifA.NeedSeedxSO, wordA);
    end
    reset = 1'b0;
    tick();
    checks++;
    if (ifA.SeedReadyxSO !== 1'b1) begin
      errors++;
      $display("[TB] FAIL idle_ready: got %b expected 1", ifA.SeedReadyxSO);
    end
  endtask

  task automatic test_seed_ones();
    for (int k = 0; k < RND_W; k++) seedVals[k] = 32'h1;
    seed_beats(0, RND_W);
    load_model();
    checks++;
    if (ifA.RndValidxSO !== 1'b0) begin
      errors++;
      $display("[TB] FAIL warm0_invalid: got valid=%b expected 0", ifA.RndValidxSO);
    end
    tick();
    checks++;
    if (ifA.RndValidxSO !== 1'b1 || wordA !== 12'hFFF) begin
      errors++;
      $display("[TB] FAIL first_word: got valid=%b word=%h expected 1 FFF", ifA.RndValidxSO, wordA);
    end
    run_xfers(40);
  endtask

  task automatic test_zero_seed();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int k = 0; k < RND_W; k++) seedVals[k] = 32'h1;
    seedVals[5] = 32'h8000_0000;
    seed_beats(0, RND_W);
    load_model();
    tick();
    checks++;
    if (wordA !== 12'hFFF) begin
      errors++;
      $display("[TB] FAIL zero_seed_first: got %h expected FFF", wordA);
    end
    run_xfers(35);
  endtask

  task automatic test_stall();
    logic [11:0] held;
    held = mdl_word();
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (ifA.RndValidxSO !== 1'b1 || wordA !== held) begin
        errors++;
        $display("[TB] FAIL stall_hold: got valid=%b word=%h expected 1 %h", ifA.RndValidxSO, wordA, held);
      end
    end
    run_xfers(5);
  endtask

  task automatic test_warmup();
    logic [30:0] saved [RND_W];
    int cnt;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int k = 0; k < RND_W; k++) seedVals[k] = $urandom;
    seed_beats(0, RND_W);
    load_model();
    cnt = 0;
    while (ifB.RndValidxSO !== 1'b1 && cnt < 200) begin
      if (cnt == 10) begin
        checks++;
        if (ifB.SeedReadyxSO !== 1'b0 || ifB.NeedSeedxSO !== 1'b0) begin
          errors++;
          $display("[TB] FAIL warm_flags: got ready=%b need=%b expected 0 0", ifB.SeedReadyxSO, ifB.NeedSeedxSO);
        end
      end
      tick();
      cnt++;
    end
    checks++;
    if (cnt != 65) begin
      errors++;
      $display("[TB] FAIL warm_latency: got %0d cycles expected 65", cnt);
    end
    saved = mdl;
    for (int i = 0; i < 64; i++) mdl_step();
    checks++;
    if (wordB !== mdl_word()) begin
      errors++;
      $display("[TB] FAIL warm_word: got %h expected %h", wordB, mdl_word());
    end
    mdl = saved;
    run_xfers(20);
  endtask

  task automatic test_reseed_xfer();
    readyA  = 1'b1;
    reseedA = 1'b1;
    if (ifA.RndValidxSO === 1'b1) begin
      expQ.push_back(mdl_word());
      mdl_step();
    end
    tick();
    readyA  = 1'b0;
    reseedA = 1'b0;
    checks++;
    if (ifA.RndValidxSO !== 1'b0 || ifA.NeedSeedxSO !== 1'b1 || ifA.SeedReadyxSO !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reseed_flags: got valid=%b need=%b ready=%b expected 0 1 1",
               ifA.RndValidxSO, ifA.NeedSeedxSO, ifA.SeedReadyxSO);
    end
    for (int k = 0; k < RND_W; k++) seedVals[k] = $urandom;
    seed_beats(0, RND_W);
    load_model();
    run_xfers(30);
  endtask

  task automatic test_reset_mid_seed();
    for (int k = 0; k < RND_W; k++) seedVals[k] = 32'hDEAD_0000 + k;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    seed_beats(0, 5);
    reset = 1'b1;
    tick();
    checks++;
    if (ifA.RndValidxSO !== 1'b0 || ifA.SeedReadyxSO !== 1'b0 || ifA.NeedSeedxSO !== 1'b1 || wordA !== 12'h000) begin
      errors++;
      $display("[TB] FAIL midseed_reset: got valid=%b ready=%b need=%b word=%h expected 0 0 1 000",
               ifA.RndValidxSO, ifA.SeedReadyxSO, ifA.NeedSeedxSO, wordA);
    end
    reset = 1'b0;
    for (int k = 0; k < RND_W; k++) seedVals[k] = 32'h0BAD_F00D ^ (32'h1357 * k);
    seed_beats(0, RND_W);
    load_model();
    run_xfers(25);
  endtask

  initial begin
    $display("[TB] start");
    test_reset();
    test_seed_ones();
    test_zero_seed();
    test_stall();
    test_warmup();
    test_reseed_xfer();
    test_reset_mid_seed();
    tick();
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL queue_drain: got %0d pending expected 0", expQ.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
